// File: rtl/flash_generator.sv
// Flash generator: turns single-cycle request pulses into fixed-length flashes,
// each followed by a mandatory dark gap, with up to seven requests queued.
module flash_generator #(
  parameter bit sim    = 1'b0,
  parameter int ON_MS  = 100,
  parameter int OFF_MS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic       out,
  output logic       busy,
  output logic [2:0] pending
);

  localparam logic [16:0] TICK_LAST = sim ? 17'd1 : 17'd99999;
  localparam logic [9:0]  ON_LAST   = 10'(ON_MS - 1);
  localparam logic [9:0]  OFF_LAST  = 10'(OFF_MS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [16:0] presc_r;
  logic [9:0]  timer_r;
  logic [2:0]  pending_r;
  logic [2:0]  pending_nxt_s;
  logic        out_r;
  logic        busy_r;
  logic        out_nxt_s;
  logic        busy_nxt_s;
  logic        tick_s;
  logic        phase_done_s;
  logic        restart_s;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    if (v == 3'd7) begin
      return 3'd7;
    end else begin
      return v + 3'd1;
    end
  endfunction

  assign tick_s = (presc_r == TICK_LAST);

  // Phase completion: last tick of the current ON or OFF interval
  always_comb begin
    phase_done_s = 1'b0;
    case (state_r)
      ST_ON:   phase_done_s = tick_s && (timer_r == ON_LAST);
      ST_OFF:  phase_done_s = tick_s && (timer_r == OFF_LAST);
      default: phase_done_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      pending_r <= 3'd0;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

  // Next-state and request-queue logic
  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    case (state_r)
      ST_IDLE: begin
        // The starting pulse is consumed by the flash itself.
        if (in) begin
          state_nxt_s = ST_ON;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ON: begin
        if (phase_done_s) begin
          state_nxt_s = ST_OFF;
        end else begin
          state_nxt_s = ST_ON;
        end
        pending_nxt_s = in ? sat_inc(pending_r) : pending_r;
      end
      ST_OFF: begin
        if (phase_done_s) begin
          if (pending_r != 3'd0) begin
            // A fresh pulse replaces the queued request it would otherwise consume.
            state_nxt_s   = ST_ON;
            pending_nxt_s = in ? pending_r : (pending_r - 3'd1);
          end else if (in) begin
            state_nxt_s = ST_ON;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s   = ST_OFF;
          pending_nxt_s = in ? sat_inc(pending_r) : pending_r;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        pending_nxt_s = 3'd0;
      end
    endcase
  end

  assign restart_s = (state_nxt_s != state_r) || (state_r == ST_IDLE);

  // Prescaler and tick timer, restarted on every state entry for a fixed phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r <= 17'd0;
      timer_r <= 10'd0;
    end else if (restart_s) begin
      presc_r <= 17'd0;
      timer_r <= 10'd0;
    end else if (tick_s) begin
      presc_r <= 17'd0;
      timer_r <= timer_r + 10'd1;
    end else begin
      presc_r <= presc_r + 17'd1;
    end
  end

  // Output decode from the upcoming state
  always_comb begin
    out_nxt_s  = 1'b0;
    busy_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_ON: begin
        out_nxt_s  = 1'b1;
        busy_nxt_s = 1'b1;
      end
      ST_OFF: begin
        out_nxt_s  = 1'b0;
        busy_nxt_s = 1'b1;
      end
      default: begin
        out_nxt_s  = 1'b0;
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      out_r  <= out_nxt_s;
      busy_r <= busy_nxt_s;
    end
  end

  assign out     = out_r;
  assign busy    = busy_r;
  assign pending = pending_r;

endmodule

// File: tb/tb_flash_generator.sv
// Bench for flash_generator (sim=1, P=2, ON_MS=3, OFF_MS=2): each flash should be
// 6 cycles on, followed by a 4-cycle busy gap; expected flashes go through a queue.
module tb_flash_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       in;
  logic       out;
  logic       busy;
  logic [2:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int on_len;
    int pend;
  } flash_t;

  flash_t exp_q[$];
  bit     mon_en = 1'b0;

  always #5 clk = ~clk;

  flash_generator #(.sim(1'b1), .ON_MS(3), .OFF_MS(2)) dut (
    .clk(clk), .reset(reset), .in(in), .out(out), .busy(busy), .pending(pending)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_flash(input int p);
    flash_t f;
    f.on_len = 6;
    f.pend   = p;
    exp_q.push_back(f);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: busy=%0b after 300 cycles, expected 0", name, busy);
    end
    repeat (2) @(negedge clk);
    check({name, "_missing_flashes"}, exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // Monitor: measures each flash and the dark gap after it, pops the scoreboard
  initial begin
    int     on_cnt;
    int     gap_cnt;
    int     start_pend;
    bit     prev_out;
    bit     in_gap;
    flash_t r;
    on_cnt = 0; gap_cnt = 0; start_pend = 0; prev_out = 1'b0; in_gap = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_out = 1'b0;
        in_gap   = 1'b0;
        on_cnt   = 0;
        gap_cnt  = 0;
      end else begin
        if (out) begin
          if (!prev_out) begin
            if (in_gap) begin
              check("gap_len", gap_cnt, 4);
              in_gap = 1'b0;
            end
            start_pend = int'(pending);
            on_cnt     = 1;
          end else begin
            on_cnt++;
          end
        end else if (prev_out) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_flash: got flash of %0d cycles, expected none", on_cnt);
          end else begin
            r = exp_q.pop_front();
            check("on_len", on_cnt, r.on_len);
            check("start_pending", start_pend, r.pend);
          end
          in_gap  = 1'b1;
          gap_cnt = busy ? 1 : 0;
        end else if (in_gap) begin
          if (busy) begin
            gap_cnt++;
          end else begin
            check("gap_len", gap_cnt, 4);
            in_gap = 1'b0;
          end
        end
        prev_out = out;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    in    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    reset = 1'b1;
    step(2);
    mon_en = 1'b1;

    // Single pulse: out k+1..k+6, busy k+1..k+10, idle at k+11
    expect_flash(0);
    in = 1'b1; step(1); in = 1'b0;
    @(negedge clk);
    check("t1_out_k1", out, 1);
    check("t1_pend_k1", pending, 0);
    repeat (9) @(negedge clk);
    check("t1_busy_k10", busy, 1);
    check("t1_out_k10", out, 0);
    @(negedge clk);
    check("t1_busy_k11", busy, 0);
    wait_idle("t1");

    // Three consecutive pulses: queue reaches 2, drains 2->1->0
    expect_flash(0); expect_flash(1); expect_flash(0);
    in = 1'b1; step(3); in = 1'b0;
    @(negedge clk);
    check("t2_pend_peak", pending, 2);
    wait_idle("t2");

    // Ten back-to-back pulses: queue saturates at 7, eight flashes in total
    expect_flash(0); expect_flash(6); expect_flash(5); expect_flash(4);
    expect_flash(3); expect_flash(2); expect_flash(1); expect_flash(0);
    in = 1'b1; step(10); in = 1'b0;
    @(negedge clk);
    check("t3_pend_sat", pending, 7);
    wait_idle("t3");

    // Pulse on the final OFF cycle with an empty queue
    expect_flash(0); expect_flash(0);
    in = 1'b1; step(1); in = 1'b0;
    step(9);
    in = 1'b1; step(1); in = 1'b0;
    @(negedge clk);
    check("t4a_out", out, 1);
    check("t4a_pend", pending, 0);
    wait_idle("t4a");

    // Pulse on the final OFF cycle with three queued: net queue unchanged
    expect_flash(0); expect_flash(3); expect_flash(2); expect_flash(1); expect_flash(0);
    in = 1'b1; step(4); in = 1'b0;
    step(6);
    in = 1'b1; step(1); in = 1'b0;
    @(negedge clk);
    check("t4b_out", out, 1);
    check("t4b_pend", pending, 3);
    wait_idle("t4b");

    // Asynchronous reset mid-flash with four queued
    mon_en = 1'b0;
    in = 1'b1; step(5); in = 1'b0;
    check("t5_pend_pre", pending, 4);
    check("t5_out_pre", out, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_out", out, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_pend", pending, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    step(3);
    check("t5_idle_busy", busy, 0);
    check("t5_idle_out", out, 0);
    check("t5_idle_pend", pending, 0);

    // First pulse after reset behaves like a fresh single flash
    mon_en = 1'b1;
    expect_flash(0);
    in = 1'b1; step(1); in = 1'b0;
    @(negedge clk);
    check("t6_out_k1", out, 1);
    check("t6_busy_k1", busy, 1);
    wait_idle("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
